// File: rtl/tm1637_pkg.sv
// rtl/tm1637_pkg.sv - shared state encoding and timing constants for the TM1637 burst master
package tm1637_pkg;

  localparam int HALF_CYC_DEFAULT = 256;
  // Wide enough for the largest legal half-bit length (1023)
  localparam int PHASE_CNT_W = 10;

  typedef enum logic [3:0] {
    IDLE,
    START,
    BIT_LO,
    BIT_HI,
    ACK_LO,
    ACK_HI,
    HOLD,
    RD_LO,
    RD_HI,
    RACK_LO,
    RACK_HI,
    STOP_A,
    STOP_B,
    STOP_C
  } state_t;

endpackage

// File: rtl/tm1637_phase_timer.sv
// rtl/tm1637_phase_timer.sv - half-bit phase counter with single-cycle done at HALF_CYC-1
module tm1637_phase_timer
  import tm1637_pkg::*;
#(
  parameter int HALF_CYC = HALF_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic done
);

  localparam logic [PHASE_CNT_W-1:0] LAST = PHASE_CNT_W'(HALF_CYC - 1);

  logic [PHASE_CNT_W-1:0] r_cnt;

  // Saturates at LAST so untimed states never wrap the count
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      r_cnt <= '0;
    end else if (!done) begin
      r_cnt <= r_cnt + PHASE_CNT_W'(1);
    end
  end

  assign done = (r_cnt == LAST);

endmodule

// File: rtl/tm1637_burst.sv
// rtl/tm1637_burst.sv - TM1637 two-wire burst master: byte stream in, open-drain SCL/SDA out
module tm1637_burst
  import tm1637_pkg::*;
#(
  parameter int HALF_CYC  = HALF_CYC_DEFAULT,
  parameter int ACK_CHECK = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  input  logic       s_rd,
  output logic       s_ready,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       busy,
  output logic       ack_err,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in
);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_byte;
  logic [7:0] r_m_data;
  logic [2:0] r_idx;
  logic       r_last;
  logic       r_rd;
  logic       r_ack_err;
  logic       r_m_valid;

  logic       w_done;
  logic       w_restart;
  logic       w_accept;
  logic       w_hi_done;
  logic       w_idx_clr;

  tm1637_phase_timer #(
    .HALF_CYC(HALF_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(w_restart),
    .done   (w_done)
  );

  assign s_ready  = ((r_state == IDLE) || (r_state == HOLD)) && !rst;
  assign w_accept = s_valid && s_ready;

  always_comb begin
    w_next = r_state;
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = START;
      end
      START: begin
        sda_oe = 1'b1;
        if (w_done) w_next = BIT_LO;
      end
      BIT_LO: begin
        scl_oe = 1'b1;
        sda_oe = ~r_byte[r_idx];
        if (w_done) w_next = BIT_HI;
      end
      BIT_HI: begin
        sda_oe = ~r_byte[r_idx];
        if (w_done) w_next = (r_idx == 3'd7) ? ACK_LO : BIT_LO;
      end
      ACK_LO: begin
        scl_oe = 1'b1;
        if (w_done) w_next = ACK_HI;
      end
      ACK_HI: begin
        // Read frames carry only the command byte before the single read byte
        if (w_done) begin
          if (r_rd)        w_next = RD_LO;
          else if (r_last) w_next = STOP_A;
          else             w_next = HOLD;
        end
      end
      HOLD: begin
        scl_oe = 1'b1;
        if (w_accept) w_next = BIT_LO;
      end
      RD_LO: begin
        scl_oe = 1'b1;
        if (w_done) w_next = RD_HI;
      end
      RD_HI: begin
        if (w_done) w_next = (r_idx == 3'd7) ? RACK_LO : RD_LO;
      end
      RACK_LO: begin
        scl_oe = 1'b1;
        sda_oe = 1'b1;
        if (w_done) w_next = RACK_HI;
      end
      RACK_HI: begin
        sda_oe = 1'b1;
        if (w_done) w_next = STOP_A;
      end
      STOP_A: begin
        scl_oe = 1'b1;
        sda_oe = 1'b1;
        if (w_done) w_next = STOP_B;
      end
      STOP_B: begin
        sda_oe = 1'b1;
        if (w_done) w_next = STOP_C;
      end
      STOP_C: begin
        if (w_done) w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign w_restart = (w_next != r_state);
  assign w_hi_done = ((r_state == BIT_HI) || (r_state == RD_HI)) && w_done;
  assign w_idx_clr = w_restart &&
                     ((r_state == START) || (r_state == HOLD) || (r_state == ACK_HI));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_byte    <= '0;
      r_m_data  <= '0;
      r_idx     <= '0;
      r_last    <= 1'b0;
      r_rd      <= 1'b0;
      r_ack_err <= 1'b0;
      r_m_valid <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_m_valid <= (r_state == RACK_HI) && w_done;

      if (w_accept) begin
        r_byte <= s_data;
        r_last <= s_last;
      end

      if (w_accept && (r_state == IDLE)) begin
        r_rd      <= s_rd;
        r_ack_err <= 1'b0;
      end else if ((ACK_CHECK != 0) && (r_state == ACK_HI) && w_done && sda_in) begin
        r_ack_err <= 1'b1;
      end

      if (w_idx_clr) begin
        r_idx <= '0;
      end else if (w_hi_done) begin
        r_idx <= r_idx + 3'd1;
      end

      if ((r_state == RD_HI) && w_done) begin
        r_m_data[r_idx] <= sda_in;
      end
    end
  end

  assign busy    = (r_state != IDLE);
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign ack_err = (ACK_CHECK != 0) ? r_ack_err : 1'b0;

endmodule
